// File: rtl/uart_axil_master_if.sv
// Bundles the UART word-FIFO handshake and the AXI4-lite master channels
// into one port; the master modport is the command engine's view.
interface uart_axil_master_if #(
  parameter int ADDR_W = 32
);
  logic              rx_empty;
  logic [31:0]       rfifo_data_out;
  logic              rfifo_pop;
  logic              tx_full;
  logic              tfifo_push;
  logic [31:0]       tfifo_data_in;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    input  rx_empty, rfifo_data_out, tx_full,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    input  m_arready, m_rdata, m_rresp, m_rvalid,
    output rfifo_pop, tfifo_push, tfifo_data_in,
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_araddr, m_arvalid, m_rready
  );

  modport slave (
    output rx_empty, rfifo_data_out, tx_full,
    output m_awready, m_wready, m_bresp, m_bvalid,
    output m_arready, m_rdata, m_rresp, m_rvalid,
    input  rfifo_pop, tfifo_push, tfifo_data_in,
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_araddr, m_arvalid, m_rready
  );
endinterface

// File: rtl/uart_axil_master.sv
// Command engine: pops header/address/data words from the UART RX FIFO, runs one
// AXI4-lite read or write, and pushes a status word (plus read data) to the TX FIFO.
module uart_axil_master #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  uart_axil_master_if.master  bus,
  output logic                busy
);

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, PUT_STAT, PUT_DATA
  } state_t;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  state_t            state_q;
  logic [1:0]        op_q;
  logic [3:0]        strb_q;
  logic [1:0]        resp_q;
  logic [31:0]       rdata_q;
  logic              pop_gap_q;
  logic              push_q;
  logic [31:0]       tdata_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              aw_done;
  logic              w_done;

  function automatic logic [31:0] status_word(input logic [1:0] op, input logic [1:0] resp);
    logic bad;
    bad = (op != OP_WR) && (op != OP_RD);
    return {27'd0, bad, op, resp};
  endfunction

  // Pops skip the cycle after a pop so rx_empty reflects the FIFO's new head.
  assign bus.rfifo_pop = ~bus.rx_empty & ~pop_gap_q &
                         ((state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA));

  assign aw_done = ~awvalid_q | bus.m_awready;
  assign w_done  = ~wvalid_q | bus.m_wready;

  assign bus.tfifo_push    = push_q;
  assign bus.tfifo_data_in = tdata_q;
  assign bus.m_awaddr      = awaddr_q;
  assign bus.m_awvalid     = awvalid_q;
  assign bus.m_wdata       = wdata_q;
  assign bus.m_wstrb       = wstrb_q;
  assign bus.m_wvalid      = wvalid_q;
  assign bus.m_bready      = bready_q;
  assign bus.m_araddr      = araddr_q;
  assign bus.m_arvalid     = arvalid_q;
  assign bus.m_rready      = rready_q;
  assign busy              = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      strb_q    <= 4'h0;
      resp_q    <= 2'b00;
      rdata_q   <= 32'h0;
      pop_gap_q <= 1'b0;
      push_q    <= 1'b0;
      tdata_q   <= 32'h0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      pop_gap_q <= bus.rfifo_pop;
      case (state_q)
        IDLE: if (bus.rfifo_pop) begin
          op_q   <= bus.rfifo_data_out[1:0];
          strb_q <= bus.rfifo_data_out[7:4];
          resp_q <= 2'b00;
          if ((bus.rfifo_data_out[1:0] == OP_WR) || (bus.rfifo_data_out[1:0] == OP_RD)) begin
            state_q <= GET_ADDR;
          end else begin
            state_q <= PUT_STAT;
            // tx_full is checked one cycle ahead so the push can land on PUT_STAT entry.
            if (!bus.tx_full) begin
              push_q  <= 1'b1;
              tdata_q <= status_word(bus.rfifo_data_out[1:0], 2'b00);
            end
          end
        end
        GET_ADDR: if (bus.rfifo_pop) begin
          if (op_q == OP_WR) begin
            awaddr_q <= bus.rfifo_data_out[ADDR_W-1:0];
            state_q  <= GET_DATA;
          end else begin
            araddr_q  <= bus.rfifo_data_out[ADDR_W-1:0];
            arvalid_q <= 1'b1;
            state_q   <= RD_REQ;
          end
        end
        GET_DATA: if (bus.rfifo_pop) begin
          wdata_q   <= bus.rfifo_data_out;
          wstrb_q   <= strb_q;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          state_q   <= WR_REQ;
        end
        WR_REQ: begin
          if (bus.m_awready) awvalid_q <= 1'b0;
          if (bus.m_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (bus.m_bvalid) begin
          bready_q <= 1'b0;
          resp_q   <= bus.m_bresp;
          state_q  <= PUT_STAT;
          if (!bus.tx_full) begin
            push_q  <= 1'b1;
            tdata_q <= status_word(op_q, bus.m_bresp);
          end
        end
        RD_REQ: if (bus.m_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_RESP;
        end
        RD_RESP: if (bus.m_rvalid) begin
          rready_q <= 1'b0;
          rdata_q  <= bus.m_rdata;
          resp_q   <= bus.m_rresp;
          state_q  <= PUT_STAT;
          if (!bus.tx_full) begin
            push_q  <= 1'b1;
            tdata_q <= status_word(op_q, bus.m_rresp);
          end
        end
        // push_q high means the word is being pushed this cycle; clearing it forms the gap.
        PUT_STAT: begin
          if (push_q) begin
            push_q  <= 1'b0;
            state_q <= (op_q == OP_RD) ? PUT_DATA : IDLE;
          end else if (!bus.tx_full) begin
            push_q  <= 1'b1;
            tdata_q <= status_word(op_q, resp_q);
          end
        end
        PUT_DATA: begin
          if (push_q) begin
            push_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!bus.tx_full) begin
            push_q  <= 1'b1;
            tdata_q <= rdata_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axil_master.sv
// Directed bench for uart_axil_master: RX FIFO model, AXI-lite slave model,
// and a scoreboard of expected TX words and AXI payloads checked by monitors.
module tb_uart_axil_master;
  logic clk;
  logic rst;
  logic busy;

  uart_axil_master_if #(.ADDR_W(32)) bus ();

  uart_axil_master #(.ADDR_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rxq[$];
  logic [31:0] exp_push[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [35:0] exp_w[$];
  int pop_cyc[$];
  int push_cyc[$];
  int aw_hs_cyc, b_hs_cyc;
  int aw_hi, w_hi, vld_cyc, b_n, push_n;
  int aw_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // RX FIFO model: a pop seen in cycle N removes the head before cycle N+1.
  initial begin : rx_model
    logic pp;
    bus.rx_empty       = 1'b1;
    bus.rfifo_data_out = 32'h0;
    forever begin
      @(negedge clk);
      pp = bus.rfifo_pop;
      if (pp) pop_cyc.push_back(cyc);
      @(posedge clk);
      #2;
      if (pp && rxq.size() > 0) void'(rxq.pop_front());
      bus.rx_empty       = (rxq.size() == 0);
      bus.rfifo_data_out = (rxq.size() > 0) ? rxq[0] : 32'h0;
    end
  end

  // TX monitor: pops the scoreboard on every push and checks the push rules.
  initial begin : push_mon
    logic prev_full;
    int last_push;
    prev_full = 1'b0;
    last_push = -10;
    forever begin
      @(negedge clk);
      if (!rst && bus.tfifo_push) begin
        push_n++;
        push_cyc.push_back(cyc);
        check("push_after_full", 32'(prev_full), 32'd0);
        check("push_gap_ok", 32'((cyc - last_push) >= 2), 32'd1);
        last_push = cyc;
        check("push_expected", 32'(exp_push.size() > 0), 32'd1);
        if (exp_push.size() > 0) check("push_word", bus.tfifo_data_in, exp_push.pop_front());
      end
      prev_full = bus.tx_full;
    end
  end

  // AXI-lite slave model and channel monitor; readies/valids change at negedge.
  initial begin : slave
    int aw_cnt;
    logic aw_got, w_got, b_arm, b_hs, r_arm, r_hs;
    logic [35:0] ew;
    aw_cnt = 0; aw_got = 0; w_got = 0; b_arm = 0; b_hs = 0; r_arm = 0; r_hs = 0;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_cnt = 0; aw_got = 0; w_got = 0; b_arm = 0; b_hs = 0; r_arm = 0; r_hs = 0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_arready = 0;
        bus.m_rvalid = 0;
      end else begin
        if (bus.m_awvalid) aw_hi++;
        if (bus.m_wvalid) w_hi++;
        if (bus.m_awvalid || bus.m_wvalid || bus.m_arvalid) vld_cyc++;
        if (b_hs) begin bus.m_bvalid = 0; b_hs = 0; end
        if (b_arm) begin bus.m_bvalid = 1; bus.m_bresp = cfg_bresp; b_arm = 0; end
        if (bus.m_bvalid && bus.m_bready) begin b_hs = 1; b_n++; b_hs_cyc = cyc; end
        if (r_hs) begin bus.m_rvalid = 0; r_hs = 0; end
        if (r_arm) begin
          bus.m_rvalid = 1; bus.m_rdata = cfg_rdata; bus.m_rresp = cfg_rresp; r_arm = 0;
        end
        if (bus.m_rvalid && bus.m_rready) r_hs = 1;
        bus.m_awready = (aw_delay == 0) || (bus.m_awvalid && aw_cnt >= aw_delay);
        if (bus.m_awvalid) begin
          if (bus.m_awready) begin
            aw_cnt = 0; aw_got = 1; aw_hs_cyc = cyc;
            check("aw_expected", 32'(exp_aw.size() > 0), 32'd1);
            if (exp_aw.size() > 0) check("aw_addr", bus.m_awaddr, exp_aw.pop_front());
          end else begin
            aw_cnt++;
          end
        end
        bus.m_wready = 1;
        if (bus.m_wvalid) begin
          w_got = 1;
          check("w_expected", 32'(exp_w.size() > 0), 32'd1);
          if (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            check("w_data", bus.m_wdata, ew[31:0]);
            check("w_strb", 32'(bus.m_wstrb), 32'(ew[35:32]));
          end
        end
        if (aw_got && w_got) begin b_arm = 1; aw_got = 0; w_got = 0; end
        bus.m_arready = 1;
        if (bus.m_arvalid) begin
          r_arm = 1;
          check("ar_expected", 32'(exp_ar.size() > 0), 32'd1);
          if (exp_ar.size() > 0) check("ar_addr", bus.m_araddr, exp_ar.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (k < 300 && !(push_n >= target && !busy)) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("done_in_time", 32'(k < 300), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, bn0, k;
    total = 0; bad = 0; cyc = 0;
    aw_hi = 0; w_hi = 0; vld_cyc = 0; b_n = 0; push_n = 0;
    aw_hs_cyc = 0; b_hs_cyc = 0;
    aw_delay = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0;
    bus.tx_full = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({bus.rfifo_pop, bus.tfifo_push, bus.m_awvalid, bus.m_wvalid,
                           bus.m_arvalid, bus.m_bready, bus.m_rready, busy}), 32'd0);
    check("rst_tdata", bus.tfifo_data_in, 32'h0);
    check("rst_awaddr", bus.m_awaddr, 32'h0);
    check("rst_araddr", bus.m_araddr, 32'h0);
    check("rst_wdata", bus.m_wdata, 32'h0);
    check("rst_wstrb", 32'(bus.m_wstrb), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write, zero-wait slave: latency relative to the header pop.
    pop_cyc.delete(); push_cyc.delete();
    exp_aw.push_back(32'h0000_0010);
    exp_w.push_back({4'hF, 32'hDEAD_BEEF});
    exp_push.push_back(32'h0000_0004);
    base = push_n;
    rxq.push_back(32'h0000_00F1); rxq.push_back(32'h0000_0010); rxq.push_back(32'hDEAD_BEEF);
    wait_done(base + 1);
    check("wr_pops", 32'(pop_cyc.size()), 32'd3);
    check("wr_addr_pop_cyc", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
    check("wr_data_pop_cyc", 32'(pop_cyc[2] - pop_cyc[0]), 32'd4);
    check("wr_aw_hs_cyc", 32'(aw_hs_cyc - pop_cyc[0]), 32'd5);
    check("wr_b_hs_cyc", 32'(b_hs_cyc - pop_cyc[0]), 32'd6);
    check("wr_push_cyc", 32'(push_cyc[0] - pop_cyc[0]), 32'd7);

    // Read, zero-wait slave.
    exp_ar.push_back(32'h0000_0020);
    exp_push.push_back(32'h0000_0008);
    exp_push.push_back(32'h1234_5678);
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    base = push_n;
    rxq.push_back(32'h0000_0002); rxq.push_back(32'h0000_0020);
    wait_done(base + 2);
    check("rd_push_count", 32'(push_n - base), 32'd2);

    // Write with awready delayed 3 cycles, wready immediate, bresp=01.
    aw_delay = 3; cfg_bresp = 2'b01;
    aw_hi = 0; w_hi = 0; bn0 = b_n; base = push_n;
    exp_aw.push_back(32'h0000_0030);
    exp_w.push_back({4'h3, 32'h0BAD_F00D});
    exp_push.push_back(32'h0000_0005);
    rxq.push_back(32'h0000_0031); rxq.push_back(32'h0000_0030); rxq.push_back(32'h0BAD_F00D);
    wait_done(base + 1);
    check("slow_aw_valid_cycles", 32'(aw_hi), 32'd4);
    check("slow_w_valid_cycles", 32'(w_hi), 32'd1);
    check("slow_b_count", 32'(b_n - bn0), 32'd1);
    check("slow_push_count", 32'(push_n - base), 32'd1);
    aw_delay = 0; cfg_bresp = 2'b00;

    // Invalid opcode 11: header only, no AXI traffic.
    pop_cyc.delete(); vld_cyc = 0; base = push_n;
    exp_push.push_back(32'h0000_001C);
    rxq.push_back(32'h0000_0003);
    wait_done(base + 1);
    repeat (3) @(posedge clk);
    #1;
    check("bad_no_axi_valid", 32'(vld_cyc), 32'd0);
    check("bad_pop_count", 32'(pop_cyc.size()), 32'd1);
    check("bad_push_count", 32'(push_n - base), 32'd1);

    // Read under TX backpressure, rresp=10.
    push_cyc.delete(); base = push_n;
    cfg_rdata = 32'hA5A5_5A5A; cfg_rresp = 2'b10;
    exp_ar.push_back(32'h0000_0024);
    exp_push.push_back(32'h0000_000A);
    exp_push.push_back(32'hA5A5_5A5A);
    bus.tx_full = 1'b1;
    rxq.push_back(32'h0000_0002); rxq.push_back(32'h0000_0024);
    repeat (10) @(posedge clk);
    #1;
    check("full_no_push", 32'(push_n - base), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    bus.tx_full = 1'b0;
    wait_done(base + 2);
    check("full_push_spacing", 32'((push_cyc[1] - push_cyc[0]) >= 2), 32'd1);
    cfg_rresp = 2'b00;

    // Reset while the write address is stalled in WR_REQ.
    aw_delay = 20;
    exp_aw.push_back(32'h0000_0050);
    exp_w.push_back({4'hF, 32'h1111_2222});
    exp_push.push_back(32'h0000_0004);
    rxq.push_back(32'h0000_00F1); rxq.push_back(32'h0000_0050); rxq.push_back(32'h1111_2222);
    k = 0;
    while (k < 40 && !bus.m_awvalid) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rst_test_awvalid_seen", 32'(bus.m_awvalid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valids", 32'({bus.m_awvalid, bus.m_wvalid}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_aw.delete(); exp_w.delete(); exp_push.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    aw_delay = 0;
    base = push_n;
    cfg_rdata = 32'hCAFE_F00D;
    exp_ar.push_back(32'h0000_0044);
    exp_push.push_back(32'h0000_0008);
    exp_push.push_back(32'hCAFE_F00D);
    rxq.push_back(32'h0000_0002); rxq.push_back(32'h0000_0044);
    wait_done(base + 2);
    check("postrst_push_count", 32'(push_n - base), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    check("left_push", 32'(exp_push.size()), 32'd0);
    check("left_aw", 32'(exp_aw.size()), 32'd0);
    check("left_w", 32'(exp_w.size()), 32'd0);
    check("left_ar", 32'(exp_ar.size()), 32'd0);
    check("left_rx", 32'(rxq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
